// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and EX-driven redirect.
// Optional fetch counter enabled by defining IF_FETCH_CNT_EN.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    input  logic        ex_valid,
    input  logic [2:0]  ex_pc_sel,
    input  logic        ex_br_taken,
    input  logic [31:0] ex_pc_imm,
    input  logic [31:0] ex_alu_out,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid,
    output logic        redirect,
    output logic        misalign,
    output logic [31:0] fetch_cnt
);

    localparam logic [2:0] SEL_ALU = 3'b010;
    localparam logic [2:0] SEL_IMM = 3'b011;

    logic [31:0] pc_q, pc_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        id_valid_q, id_valid_d;
    logic        misalign_q, misalign_d;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic        fetch_en;

    // Unlisted select codes fall through to sequential fetch.
    assign redirect = ex_valid &&
                      ((ex_pc_sel == SEL_ALU) || ((ex_pc_sel == SEL_IMM) && ex_br_taken));
    assign target   = (ex_pc_sel == SEL_ALU) ? (ex_alu_out & 32'hFFFF_FFFE) : ex_pc_imm;
    assign pc_plus4 = pc_q + 32'd4;
    assign fetch_en = !redirect && !stall;

    always_comb begin
        pc_d       = pc_q;
        id_pc_d    = id_pc_q;
        id_pc4_d   = id_pc4_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        misalign_d = 1'b0;
        if (redirect) begin
            // Bubble wins even if the hazard unit asks to stall.
            pc_d       = target & 32'hFFFF_FFFC;
            id_pc_d    = 32'd0;
            id_pc4_d   = 32'd0;
            id_inst_d  = NOP_INST;
            id_valid_d = 1'b0;
            misalign_d = target[1];
        end else if (fetch_en) begin
            pc_d       = pc_plus4;
            id_pc_d    = pc_q;
            id_pc4_d   = pc_plus4;
            id_inst_d  = imem_rdata;
            id_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc_q       <= RESET_PC;
            id_pc_q    <= 32'd0;
            id_pc4_q   <= 32'd0;
            id_inst_q  <= NOP_INST;
            id_valid_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef IF_FETCH_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (fetch_en && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fetch_cnt = cnt_q;
`else
    assign fetch_cnt = 32'd0;
`endif

    assign imem_addr   = pc_q;
    assign if_id_pc    = id_pc_q;
    assign if_id_pc4   = id_pc4_q;
    assign if_id_inst  = id_inst_q;
    assign if_id_valid = id_valid_q;
    assign misalign    = misalign_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reference model feeds an expected queue, popped after each edge.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] id_pc;
        logic [31:0] id_pc4;
        logic [31:0] id_inst;
        logic        id_valid;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;
    localparam int W = $bits(exp_t);

    logic        clk;
    logic        rstn;
    logic        stall;
    logic        ex_valid;
    logic [2:0]  ex_pc_sel;
    logic        ex_br_taken;
    logic [31:0] ex_pc_imm;
    logic [31:0] ex_alu_out;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_inst;
    logic        if_id_valid;
    logic        redirect;
    logic        misalign;
    logic [31:0] fetch_cnt;

    logic [W-1:0] exp_q[$];
    int n_assert = 0;
    int n_fail   = 0;
    exp_t m;

    if_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .clk(clk), .rstn(rstn), .stall(stall), .ex_valid(ex_valid),
        .ex_pc_sel(ex_pc_sel), .ex_br_taken(ex_br_taken), .ex_pc_imm(ex_pc_imm),
        .ex_alu_out(ex_alu_out), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4), .if_id_inst(if_id_inst),
        .if_id_valid(if_id_valid), .redirect(redirect), .misalign(misalign),
        .fetch_cnt(fetch_cnt)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Driver: apply one cycle of inputs, advance the model, compare after the edge.
    task automatic step(input logic rst_n, input logic st, input logic ev,
                        input logic [2:0] sel, input logic br,
                        input logic [31:0] imm, input logic [31:0] alu);
        logic        exp_redir;
        logic [31:0] tgt;
        exp_t        e;
        rstn = rst_n; stall = st; ex_valid = ev; ex_pc_sel = sel;
        ex_br_taken = br; ex_pc_imm = imm; ex_alu_out = alu;
        #1;
        exp_redir = ev && ((sel == 3'b010) || ((sel == 3'b011) && br));
        chk("redirect", {31'd0, redirect}, {31'd0, exp_redir});
        chk("imem_addr", imem_addr, m.pc);
        if (!rst_n) begin
            m.pc = RESET_PC; m.id_pc = 0; m.id_pc4 = 0; m.id_inst = NOP_INST;
            m.id_valid = 0; m.mis = 0; m.cnt = 0;
        end else if (exp_redir) begin
            tgt = (sel == 3'b010) ? {alu[31:1], 1'b0} : imm;
            m.pc = {tgt[31:2], 2'b00};
            m.id_pc = 0; m.id_pc4 = 0; m.id_inst = NOP_INST; m.id_valid = 0;
            m.mis = tgt[1];
        end else if (st) begin
            m.mis = 0;
        end else begin
            m.id_pc = m.pc; m.id_pc4 = m.pc + 32'd4; m.id_inst = mem_word(m.pc);
            m.id_valid = 1; m.mis = 0; m.pc = m.pc + 32'd4;
`ifdef IF_FETCH_CNT_EN
            if (m.cnt != 32'hFFFF_FFFF) m.cnt = m.cnt + 32'd1;
`endif
        end
        exp_q.push_back(m);
        @(posedge clk);
        #1;
        e = exp_t'(exp_q.pop_front());
        chk("pc", imem_addr, e.pc);
        chk("if_id_pc", if_id_pc, e.id_pc);
        chk("if_id_pc4", if_id_pc4, e.id_pc4);
        chk("if_id_inst", if_id_inst, e.id_inst);
        chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.id_valid});
        chk("misalign", {31'd0, misalign}, {31'd0, e.mis});
        chk("fetch_cnt", fetch_cnt, e.cnt);
    endtask

    task automatic run(input logic st);
        step(1'b1, st, 1'b0, 3'b000, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        m = '0;
        rstn = 1'b0; stall = 1'b1; ex_valid = 1'b1; ex_pc_sel = 3'b010;
        ex_br_taken = 1'b1; ex_pc_imm = 32'h0000_5000; ex_alu_out = 32'h0000_6002;
        repeat (2) @(posedge clk);
        #1;
        // Reset overrides a pending redirect and stall
        chk("rst_pc", imem_addr, RESET_PC);
        chk("rst_inst", if_id_inst, NOP_INST);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_id_pc", if_id_pc, 32'd0);
        chk("rst_id_pc4", if_id_pc4, 32'd0);
        chk("rst_mis", {31'd0, misalign}, 32'd0);
        chk("rst_cnt", fetch_cnt, 32'd0);
        m.pc = RESET_PC; m.id_inst = NOP_INST;

        run(1'b0);
        chk("first_fetch_pc", if_id_pc, 32'h0000_3000);
        chk("first_fetch_valid", {31'd0, if_id_valid}, 32'd1);
        run(1'b0);
        chk("second_fetch_pc", if_id_pc, 32'h0000_3004);
        run(1'b0);
        chk("third_fetch_pc", if_id_pc, 32'h0000_3008);
        chk("third_fetch_inst", if_id_inst, 32'h3008_CFF7);

        run(1'b1);
        run(1'b1);
        chk("stall_hold_pc", imem_addr, 32'h0000_300C);
        chk("stall_hold_id", if_id_pc, 32'h0000_3008);
        run(1'b0);
        chk("resume_pc", if_id_pc, 32'h0000_300C);

        step(1'b1, 1'b0, 1'b1, 3'b011, 1'b1, 32'h0000_3100, 32'h0);
        chk("br_bubble_inst", if_id_inst, 32'h0000_0013);
        chk("br_bubble_valid", {31'd0, if_id_valid}, 32'd0);
        run(1'b0);
        chk("br_target_pc", if_id_pc, 32'h0000_3100);

        step(1'b1, 1'b1, 1'b1, 3'b010, 1'b0, 32'h0, 32'h0000_3203);
        chk("jalr_pc", imem_addr, 32'h0000_3200);
        chk("jalr_mis", {31'd0, misalign}, 32'd1);
        run(1'b0);
        chk("jalr_mis_clear", {31'd0, misalign}, 32'd0);
        step(1'b1, 1'b0, 1'b1, 3'b011, 1'b0, 32'h0000_7000, 32'h0);
        step(1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 32'h0, 32'h0000_8000);
        step(1'b1, 1'b0, 1'b1, 3'b111, 1'b1, 32'h0000_9000, 32'h0000_A000);
        step(1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 32'h0000_9000, 32'h0000_A000);
        step(1'b1, 1'b0, 1'b1, 3'b011, 1'b1, 32'h0000_4006, 32'h0);
        chk("imm_mis", {31'd0, misalign}, 32'd1);

        step(1'b1, 1'b0, 1'b1, 3'b011, 1'b1, 32'hFFFF_FFFC, 32'h0);
        run(1'b0);
        chk("wrap_pc", imem_addr, 32'h0000_0000);
        chk("wrap_pc4", if_id_pc4, 32'h0000_0000);
        chk("wrap_id_pc", if_id_pc, 32'hFFFF_FFFC);

        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 $urandom, $urandom);
        end

        step(1'b0, 1'b0, 1'b1, 3'b010, 1'b1, 32'h0, 32'h0000_5550);
        chk("midrst_pc", imem_addr, 32'h0000_3000);
        chk("midrst_cnt", fetch_cnt, 32'd0);

        run(1'b0);
        run(1'b0);
        run(1'b1);
        run(1'b0);
        step(1'b1, 1'b0, 1'b1, 3'b011, 1'b1, 32'h0000_3400, 32'h0);
        run(1'b0);
        run(1'b0);
`ifdef IF_FETCH_CNT_EN
        chk("cnt_five", fetch_cnt, 32'd5);
`else
        chk("cnt_off", fetch_cnt, 32'd0);
`endif
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
